// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
//
// Time-multiplexed scan driver for a 4-digit seven-segment display.
// The display value is latched once per frame, so the digits of one frame
// always come from the same number. The driver sends the latched value and
// the current digit index to an external combinational hex encoder. It
// registers the returned segment code and steps through the digit anodes.
// Every digit slot starts with a short all-dark gap that suppresses ghosting.
// The block also does leading-zero blanking and per-digit decimal points.
//
// Parameters
//   DIV           clk cycles per digit slot (blank gap + on-time), > BLANK_CYCLES
//   BLANK_CYCLES  dark cycles at the start of each slot, >= 2
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          scan enable; low blanks the display and restarts scanning
//   number[13:0] value to display
//   lzb         leading-zero blanking enable
//   dp[3:0]     decimal point per digit (dp[k] lit with digit k)
//   code[7:0]   segment code from the encoder for (num_out, digit); [6:0] used
//   num_out[13:0] frame-latched number to the encoder
//   digit[1:0]  current digit index to the encoder, 0 = least significant
//   seg[7:0]    active-high segments, [6:0] = g..a, [7] = dp
//   an[3:0]     active-low digit anodes
//   frame_tick  one-cycle pulse after num_out has loaded a new frame value
//   ovf         high while num_out > 9999
// -----------------------------------------------------------------------------
module sseg_scan_driver #(
   parameter int DIV          = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [13:0] number,
   input  logic        lzb,
   input  logic [3:0]  dp,
   input  logic [7:0]  code,
   output logic [13:0] num_out,
   output logic [1:0]  digit,
   output logic [7:0]  seg,
   output logic [3:0]  an,
   output logic        frame_tick,
   output logic        ovf
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_M1 = CW'(BLANK_CYCLES - 1);

   typedef enum logic {PH_BLANK, PH_ON} phase_t;

   logic [CW-1:0] cnt_q,   cnt_d;
   logic [1:0]    d_q,     d_d;
   phase_t        phase_q, phase_d;
   logic [13:0]   num_q,   num_d;
   logic [7:0]    seg_q,   seg_d;
   logic          tick_q,  tick_d;
   logic          lead_zero;

   // The decimal point comes from dp, so bit 7 of the encoder output is not used.
   logic unused_code7;
   assign unused_code7 = code[7];

   // A digit above 0 is a leading zero when the frame value has fewer
   // significant digits than its position.
   always_comb begin
      lead_zero = 1'b0;
      case (d_q)
         2'd1:    lead_zero = (num_q < 14'd10);
         2'd2:    lead_zero = (num_q < 14'd100);
         2'd3:    lead_zero = (num_q < 14'd1000);
         default: lead_zero = 1'b0;
      endcase
   end

   // Next-state logic for the slot counter, digit, phase and data registers.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      cnt_d   = cnt_q;
      d_d     = d_q;
      phase_d = phase_q;
      num_d   = num_q;
      seg_d   = seg_q;
      tick_d  = 1'b0;

      if (!en) begin
         // Disabled: park at the start of a frame, dark, and track number
         // so the first frame after enable shows the current value.
         cnt_d   = '0;
         d_d     = 2'd0;
         phase_d = PH_BLANK;
         seg_d   = 8'h00;
         num_d   = number;
      end else begin
         if (d_q == 2'd0 && cnt_q == '0) begin
            num_d  = number;
            tick_d = 1'b1;
         end

         if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            d_d     = d_q + 2'd1;
            phase_d = PH_BLANK;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end

         // Capture on the last blank cycle. digit and num_out were stable for
         // the whole gap, so the encoder output has settled.
         if (cnt_q == BLANK_M1) begin
            phase_d = PH_ON;
            seg_d   = {dp[d_q], (lzb && lead_zero) ? 7'd0 : code[6:0]};
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         d_q     <= 2'd0;
         phase_q <= PH_BLANK;
         num_q   <= 14'd0;
         seg_q   <= 8'h00;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         phase_q <= phase_d;
         num_q   <= num_d;
         seg_q   <= seg_d;
         tick_q  <= tick_d;
      end
   end

   // The outputs are gated only by register values. The digit changes only
   // while phase is BLANK, so the anodes and segments stay dark across it.
   assign digit      = d_q;
   assign num_out    = num_q;
   assign frame_tick = tick_q;
   assign ovf        = (num_q > 14'd9999);
   assign an         = (phase_q == PH_ON) ? ~(4'b0001 << d_q) : 4'b1111;
   assign seg        = (phase_q == PH_ON) ? seg_q : 8'h00;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_driver
//
// Directed bench for sseg_scan_driver with DIV=8 and BLANK_CYCLES=2.
// A small decimal seven-segment encoder stands in for the downstream hex
// encoder. It drives code[7] high so that any leakage of that bit shows up.
// All expected segment and anode values are literal constants.
// -----------------------------------------------------------------------------
module tb_sseg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [13:0] number;
   logic        lzb;
   logic [3:0]  dp;
   logic [7:0]  code;
   logic [13:0] num_out;
   logic [1:0]  digit;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame_tick;
   logic        ovf;

   int n_checks = 0;
   int n_pass   = 0;
   string step = "reset";

   sseg_scan_driver #(.DIV(8), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .number     (number),
      .lzb        (lzb),
      .dp         (dp),
      .code       (code),
      .num_out    (num_out),
      .digit      (digit),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   // Downstream encoder: decimal digit 'd' of n, as a g..a segment pattern.
   function automatic logic [6:0] enc(input logic [13:0] n, input logic [1:0] d);
      int v;
      v = int'(n);
      for (int i = 0; i < int'(d); i++) v = v / 10;
      case (v % 10)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  default: return 7'h6F;
      endcase
   endfunction

   assign code = {1'b1, enc(num_out, digit)};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Starts at cnt=0 of slot k and returns at cnt=0 of the following slot.
   task automatic slot(input logic [1:0] k, input logic [3:0] exp_an, input logic [7:0] exp_seg);
      check("digit", digit, k);
      check("an_blank", an, 4'b1111);
      check("seg_blank", seg, 8'h00);
      tick(1);
      check("frame_tick", frame_tick, (k == 2'd0));
      tick(1);
      check("an_on", an, exp_an);
      check("seg_on", seg, exp_seg);
      tick(6);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; number = 14'd1234; lzb = 1'b0; dp = 4'b0000;
      #1;
      check("rst_an", an, 4'b1111);
      check("rst_seg", seg, 8'h00);
      check("rst_digit", digit, 2'd0);
      check("rst_num", num_out, 14'd0);
      check("rst_tick", frame_tick, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      #11 rst_n = 1'b1;

      // Frame 1: first edge after release latches the number and raises frame_tick.
      step = "frame1";
      @(posedge clk); #1;
      check("tick_c1", frame_tick, 1'b1);
      check("num_1234", num_out, 14'd1234);
      check("an_c1", an, 4'b1111);
      tick(1);
      check("an_d0", an, 4'b1110);
      check("seg_d0", seg, 8'h66);
      check("tick_c2", frame_tick, 1'b0);
      tick(6);
      slot(2'd1, 4'b1101, 8'h4F);
      slot(2'd2, 4'b1011, 8'h5B);
      slot(2'd3, 4'b0111, 8'h06);

      // Frame 2: full frame of 1234, frame period 32 cycles.
      step = "frame2";
      slot(2'd0, 4'b1110, 8'h66);
      slot(2'd1, 4'b1101, 8'h4F);
      slot(2'd2, 4'b1011, 8'h5B);
      slot(2'd3, 4'b0111, 8'h06);

      // Frame 3: 7 with leading-zero blanking.
      step = "lzb_on";
      number = 14'd7; lzb = 1'b1;
      slot(2'd0, 4'b1110, 8'h07);
      slot(2'd1, 4'b1101, 8'h00);
      slot(2'd2, 4'b1011, 8'h00);
      slot(2'd3, 4'b0111, 8'h00);

      // Frame 4: 7 without blanking shows zero codes.
      step = "lzb_off";
      lzb = 1'b0;
      slot(2'd0, 4'b1110, 8'h07);
      slot(2'd1, 4'b1101, 8'h3F);
      slot(2'd2, 4'b1011, 8'h3F);
      slot(2'd3, 4'b0111, 8'h3F);

      // Frame 5: number changes at frame cycle 10; frame keeps 1234.
      step = "tear";
      number = 14'd1234;
      slot(2'd0, 4'b1110, 8'h66);
      tick(2);
      number = 14'd5678;
      check("num_hold", num_out, 14'd1234);
      check("an_d1", an, 4'b1101);
      check("seg_d1", seg, 8'h4F);
      tick(6);
      slot(2'd2, 4'b1011, 8'h5B);
      slot(2'd3, 4'b0111, 8'h06);
      check("num_hold_end", num_out, 14'd1234);

      // Frame 6: 5678 now visible.
      step = "frame6";
      slot(2'd0, 4'b1110, 8'h7F);
      check("num_5678", num_out, 14'd5678);
      slot(2'd1, 4'b1101, 8'h07);
      slot(2'd2, 4'b1011, 8'h7D);
      slot(2'd3, 4'b0111, 8'h6D);

      // Frame 7: 9999 with the decimal point on digit 2.
      step = "dp";
      number = 14'd9999; dp = 4'b0100;
      slot(2'd0, 4'b1110, 8'h6F);
      check("ovf_9999", ovf, 1'b0);
      slot(2'd1, 4'b1101, 8'h6F);
      slot(2'd2, 4'b1011, 8'hEF);
      slot(2'd3, 4'b0111, 8'h6F);

      // Frame 8: 12345 sets ovf after the frame latch; modulo digits 5,4,3,2.
      step = "ovf";
      check("ovf_pre", ovf, 1'b0);
      number = 14'd12345; dp = 4'b0000;
      slot(2'd0, 4'b1110, 8'h6D);
      check("ovf_set", ovf, 1'b1);
      slot(2'd1, 4'b1101, 8'h66);
      slot(2'd2, 4'b1011, 8'h4F);
      slot(2'd3, 4'b0111, 8'h5B);

      // Frame 9: drop en in the ON part of digit 2.
      step = "en";
      number = 14'd1234;
      slot(2'd0, 4'b1110, 8'h66);
      slot(2'd1, 4'b1101, 8'h4F);
      tick(3);
      check("an_d2_on", an, 4'b1011);
      check("seg_d2_on", seg, 8'h5B);
      en = 1'b0;
      tick(1);
      check("en_an", an, 4'b1111);
      check("en_seg", seg, 8'h00);
      check("en_digit", digit, 2'd0);
      check("en_tick", frame_tick, 1'b0);
      number = 14'd4321;
      tick(1);
      check("en_num_track", num_out, 14'd4321);
      check("en_an2", an, 4'b1111);
      tick(2);
      en = 1'b1;
      slot(2'd0, 4'b1110, 8'h06);
      tick(3);
      check("an_d1_on", an, 4'b1101);
      check("seg_d1_on", seg, 8'h5B);

      // Asynchronous reset in the ON part of a slot.
      step = "async_rst";
      #3 rst_n = 1'b0;
      #1;
      check("arst_an", an, 4'b1111);
      check("arst_seg", seg, 8'h00);
      check("arst_digit", digit, 2'd0);
      check("arst_num", num_out, 14'd0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_tick", frame_tick, 1'b1);
      check("arst_num2", num_out, 14'd4321);
      tick(1);
      check("arst_an_on", an, 4'b1110);
      check("arst_seg_on", seg, 8'h06);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
